// File: rtl/calc_pkg.sv
// Shared constants and FSM encoding for the result-to-BCD display path.
package calc_pkg;

    localparam int unsigned RES_WIDTH   = 16;
    localparam int unsigned RES_DIGITS  = 5;
    localparam int unsigned DISP_MAX    = 9999;
    localparam int unsigned DISP_DIGITS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more.
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adj_c
);

    always_comb begin
        adj_c = digit;
        if (digit >= 4'd5) begin
            adj_c = digit + 4'd3;
        end
    end

endmodule

// File: rtl/result_bcd_converter.sv
// Sequential double-dabble converter turning a signed/unsigned ALU result into
// sign + BCD magnitude digits, with digit count and 4-digit overflow flags.
module result_bcd_converter
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH  = RES_WIDTH,
    parameter int unsigned DIGITS = RES_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic                  sign,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [2:0]            ndigits,
    output logic                  ovf4
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     mag_q, mag_d;
    logic [BCD_W-1:0]     bcd_sr_q, bcd_sr_d;
    logic                 neg_q, neg_d;

    logic                 busy_d, done_d, sign_d, ovf4_d;
    logic [BCD_W-1:0]     bcd_out_d;
    logic [2:0]           ndigits_d;

    logic [BCD_W-1:0]     bcd_adj_c;
    logic                 neg_in_c;
    logic [2:0]           nd_c;
    logic                 ovf_c;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (bcd_sr_q[4*g +: 4]),
            .adj_c (bcd_adj_c[4*g +: 4])
        );
    end

    // Significant-digit count and overflow beyond the 4-digit display.
    always_comb begin
        nd_c  = 3'd1;
        ovf_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_sr_q[4*i +: 4] != 4'd0) begin
                nd_c = 3'(i + 1);
                if (i >= int'(DISP_DIGITS)) begin
                    ovf_c = 1'b1;
                end
            end
        end
    end

    assign neg_in_c = is_signed & bin_in[WIDTH-1];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        bcd_sr_d  = bcd_sr_q;
        neg_d     = neg_q;
        busy_d    = busy;
        done_d    = 1'b0;
        sign_d    = sign;
        bcd_out_d = bcd_out;
        ndigits_d = ndigits;
        ovf4_d    = ovf4;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SHIFT;
                    cnt_d    = '0;
                    bcd_sr_d = '0;
                    neg_d    = neg_in_c;
                    mag_d    = neg_in_c ? (~bin_in) + WIDTH'(1) : bin_in;
                    busy_d   = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d   = DONE;
                    done_d    = 1'b1;
                    bcd_out_d = bcd_sr_q;
                    sign_d    = neg_q & (bcd_sr_q != '0);
                    ndigits_d = nd_c;
                    ovf4_d    = ovf_c;
                end else begin
                    bcd_sr_d = {bcd_adj_c[BCD_W-2:0], mag_q[WIDTH-1]};
                    mag_d    = {mag_q[WIDTH-2:0], 1'b0};
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mag_q    <= '0;
            bcd_sr_q <= '0;
            neg_q    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sign     <= 1'b0;
            bcd_out  <= '0;
            ndigits  <= 3'd1;
            ovf4     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mag_q    <= mag_d;
            bcd_sr_q <= bcd_sr_d;
            neg_q    <= neg_d;
            busy     <= busy_d;
            done     <= done_d;
            sign     <= sign_d;
            bcd_out  <= bcd_out_d;
            ndigits  <= ndigits_d;
            ovf4     <= ovf4_d;
        end
    end

endmodule

// File: tb/tb_result_bcd_converter.sv
// Scoreboard bench for result_bcd_converter: decimal reference model, queued
// expectations, done-triggered monitor.
module tb_result_bcd_converter;
    import calc_pkg::*;

    localparam int unsigned W = RES_WIDTH;
    localparam int unsigned D = RES_DIGITS;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             is_signed;
    logic [W-1:0]     bin_in;
    logic             busy;
    logic             done;
    logic             sign;
    logic [4*D-1:0]   bcd_out;
    logic [2:0]       ndigits;
    logic             ovf4;

    typedef struct {
        logic           sign;
        logic [4*D-1:0] bcd;
        logic [2:0]     nd;
        logic           ovf;
        int             acc;
    } exp_t;

    exp_t exp_q[$];
    int   errs     = 0;
    int   checks   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    result_bcd_converter #(.WIDTH(W), .DIGITS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .bin_in    (bin_in),
        .busy      (busy),
        .done      (done),
        .sign      (sign),
        .bcd_out   (bcd_out),
        .ndigits   (ndigits),
        .ovf4      (ovf4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference: plain decimal arithmetic on the integer value.
    function automatic exp_t model(input logic s, input logic [W-1:0] v, input int acc);
        exp_t e;
        int   mag;
        int   t;
        mag    = (s && v[W-1]) ? (1 << W) - int'(v) : int'(v);
        e.sign = (s && v[W-1]) && (mag != 0);
        e.bcd  = '0;
        t      = mag;
        for (int i = 0; i < int'(D); i++) begin
            e.bcd[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        e.nd = 3'd0;
        t    = mag;
        do begin
            e.nd = e.nd + 3'd1;
            t    = t / 10;
        end while (t > 0);
        e.ovf = (mag > int'(DISP_MAX));
        e.acc = acc;
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("sign",    32'(sign),    32'(e.sign));
                chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
                chk("ndigits", 32'(ndigits), 32'(e.nd));
                chk("ovf4",    32'(ovf4),    32'(e.ovf));
                chk("latency", 32'(cyc - e.acc), 32'(W + 1));
            end
        end
    end

    task automatic check_reset();
        chk("rst_busy",    32'(busy),    32'(0));
        chk("rst_done",    32'(done),    32'(0));
        chk("rst_sign",    32'(sign),    32'(0));
        chk("rst_bcd",     32'(bcd_out), 32'(0));
        chk("rst_ndigits", 32'(ndigits), 32'(1));
        chk("rst_ovf4",    32'(ovf4),    32'(0));
    endtask

    // Present one request for one edge, then scramble the inputs.
    task automatic issue(input logic s, input logic [W-1:0] v);
        @(negedge clk);
        start     = 1'b1;
        is_signed = s;
        bin_in    = v;
        exp_q.push_back(model(s, v, cyc + 1));
        @(negedge clk);
        start     = 1'b0;
        is_signed = 1'($urandom);
        bin_in    = W'($urandom);
    endtask

    task automatic run_conv(input logic s, input logic [W-1:0] v);
        exp_t e;
        int   n;
        e = model(s, v, 0);
        issue(s, v);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 32'(1));
        if (done) begin
            chk("busy_at_done", 32'(busy), 32'(1));
        end
        @(negedge clk);
        chk("busy_after", 32'(busy), 32'(0));
        chk("hold_bcd",   32'(bcd_out), 32'(e.bcd));
    endtask

    initial begin
        int dc0;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        bin_in    = '0;
        repeat (3) @(negedge clk);
        check_reset();
        rst = 1'b0;

        run_conv(1'b1, 16'h0000);
        run_conv(1'b1, 16'h04D2);
        run_conv(1'b1, 16'h270F);
        run_conv(1'b1, 16'h2710);
        run_conv(1'b1, 16'hFFFF);
        run_conv(1'b1, 16'h8000);
        run_conv(1'b0, 16'hFFFF);
        run_conv(1'b0, 16'h0009);

        // Second start mid-conversion must be dropped.
        dc0 = done_cnt;
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b1;
        bin_in    = 16'h04D2;
        exp_q.push_back(model(1'b1, 16'h04D2, cyc + 1));
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
            chk("busy_window", 32'(busy), 32'(k <= 17));
            if (k == 4) begin
                start  = 1'b1;
                bin_in = 16'h0001;
            end
            if (k == 5) start = 1'b0;
        end
        chk("single_done", 32'(done_cnt - dc0), 32'(1));

        // Reset mid-conversion aborts without a done pulse.
        dc0 = done_cnt;
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b1;
        bin_in    = 16'h04D2;
        exp_q.push_back(model(1'b1, 16'h04D2, cyc + 1));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) start = 1'b0;
        end
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_done", 32'(done_cnt - dc0), 32'(0));
        check_reset();
        run_conv(1'b1, 16'h0007);

        repeat (40) begin
            run_conv(1'($urandom), W'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
